// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
// State encoding, fetch entry layout and pc legality helper.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [31:0] INSTR_BYTES = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  // A fetch pc is illegal if misaligned or past the last word.
  function automatic logic pc_illegal(
    input logic [31:0] pc,
    input logic [31:0] mem_bytes
  );
    return (pc[1:0] != 2'b00) ||
           (pc > mem_bytes - INSTR_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO between instruction memory and decode.
// Flush wins over push and pop; a push into a full queue is legal with a pop.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_data,
  output fetch_entry_t o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [CW-1:0] o_count
);

  fetch_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_pop;
  logic          w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd];

  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr] <= i_data;
    end
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fetch_controller.sv
// Fetch unit: owns the pc, fills the prefetch queue and
// handles redirects and illegal-address faults.
module fetch_controller
  import fetch_pkg::*;
#(
  parameter int unsigned MEM_BYTES   = 256,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [31:0] LIMIT = 32'(MEM_BYTES);

  state_t       r_state;
  logic [31:0]  r_pc;
  logic         r_fault;
  logic [31:0]  r_fault_pc;

  fetch_entry_t w_in;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic [CW-1:0] w_count;
  logic         w_pop;
  logic         w_push;
  logic         w_flush;
  logic         w_illegal;

  assign w_illegal = pc_illegal(r_pc, LIMIT);
  assign w_pop     = ~w_empty & out_ready;
  assign w_flush   = redirect_valid & (r_state != IDLE);
  assign w_push    = (r_state == FETCH) & ~redirect_valid &
                     ~w_illegal & (~w_full | w_pop);
  assign w_in      = '{pc: r_pc, instr: imem_instr};

  fetch_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .i_clk  (clk),
    .i_reset(reset),
    .i_push (w_push),
    .i_pop  (w_pop),
    .i_flush(w_flush),
    .i_data (w_in),
    .o_data (w_head),
    .o_full (w_full),
    .o_empty(w_empty),
    .o_count(w_count)
  );

  assign imem_pc   = r_pc;
  assign out_valid = (w_count != '0);
  assign out_instr = w_empty ? 32'h0 : w_head.instr;
  assign out_pc    = w_empty ? 32'h0 : w_head.pc;
  assign fault     = r_fault;
  assign fault_pc  = r_fault_pc;

  // Fetch FSM: pc advance, redirect handling and sticky fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      unique case (r_state)
        IDLE: r_state <= FETCH;
        FETCH: begin
          if (redirect_valid) begin
            r_pc <= redirect_pc;
          end else if (w_illegal) begin
            r_state    <= HALT;
            r_fault    <= 1'b1;
            r_fault_pc <= r_pc;
          end else if (w_push) begin
            r_pc <= r_pc + INSTR_BYTES;
          end
        end
        HALT: begin
          if (redirect_valid) begin
            r_state <= FETCH;
            r_pc    <= redirect_pc;
            if (!pc_illegal(redirect_pc, LIMIT)) begin
              r_fault <= 1'b0;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: cycle vector table plus
// a scoreboarded streaming run to the end of memory.
module tb_fetch_controller;

  localparam int unsigned MB = 256;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fetch_controller #(
    .MEM_BYTES(MB),
    .QUEUE_DEPTH(2),
    .RESET_PC(32'h0)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fault         (fault),
    .fault_pc      (fault_pc)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0] + 16'h1234};
  endfunction

  assign imem_instr = mem_word(imem_pc);

  typedef struct {
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;
    logic        ev;
    logic [31:0] eopc;
    logic [31:0] eipc;
    int          fm;
    logic        ef;
    logic [31:0] efp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic r, input logic v, input logic [31:0] p,
    input logic y, input logic ev, input logic [31:0] eo,
    input logic [31:0] ei, input int fm, input logic ef,
    input logic [31:0] efp
  );
    vec_t t;
    t.rst = r; t.rv = v; t.rpc = p; t.rdy = y;
    t.ev = ev; t.eopc = eo; t.eipc = ei;
    t.fm = fm; t.ef = ef; t.efp = efp;
    tbl.push_back(t);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int row,
                     input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] e;
  logic        rdy;
  logic        seen;
  logic        done;

  initial begin
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;

    // startup latency and in-order delivery
    add(1,0,0,1, 0,0,0, 2,0,0);
    add(1,0,0,1, 0,0,0, 2,0,0);
    add(0,0,0,1, 0,0,0, 2,0,0);
    add(0,0,0,1, 1,0,4, 2,0,0);
    add(0,0,0,1, 1,4,8, 2,0,0);
    add(0,0,0,1, 1,8,12, 2,0,0);
    // backpressure from reset, then release
    add(1,0,0,0, 0,0,0, 2,0,0);
    add(0,0,0,0, 0,0,0, 2,0,0);
    add(0,0,0,0, 1,0,4, 1,0,0);
    add(0,0,0,0, 1,0,8, 1,0,0);
    add(0,0,0,0, 1,0,8, 1,0,0);
    add(0,0,0,0, 1,0,8, 1,0,0);
    add(0,0,0,0, 1,0,8, 1,0,0);
    add(0,0,0,1, 1,4,12, 1,0,0);
    add(0,0,0,1, 1,8,16, 1,0,0);
    add(0,0,0,1, 1,12,20, 1,0,0);
    // redirect while queue holds 8,12
    add(1,0,0,0, 0,0,0, 2,0,0);
    add(0,0,0,0, 0,0,0, 1,0,0);
    add(0,0,0,0, 1,0,4, 1,0,0);
    add(0,0,0,0, 1,0,8, 1,0,0);
    add(0,0,0,1, 1,4,12, 1,0,0);
    add(0,0,0,1, 1,8,16, 1,0,0);
    add(0,1,32'h40,1, 0,0,32'h40, 1,0,0);
    add(0,0,0,1, 1,32'h40,32'h44, 1,0,0);
    add(0,0,0,1, 1,32'h44,32'h48, 1,0,0);
    // end of memory: fault with full queue, drain, recover
    add(0,1,248,0, 0,0,248, 1,0,0);
    add(0,0,0,0, 1,248,252, 1,0,0);
    add(0,0,0,0, 1,248,256, 1,0,0);
    add(0,0,0,0, 1,248,256, 2,1,256);
    add(0,0,0,1, 1,252,256, 2,1,256);
    add(0,0,0,1, 0,0,256, 2,1,256);
    add(0,0,0,1, 0,0,256, 2,1,256);
    add(0,1,0,1, 0,0,0, 1,0,0);
    add(0,0,0,1, 1,0,4, 1,0,0);
    add(0,0,0,1, 1,4,8, 1,0,0);
    // misaligned redirect, then illegal redirect from HALT
    add(0,1,6,1, 0,0,6, 1,0,0);
    add(0,0,0,1, 0,0,6, 2,1,6);
    add(0,0,0,1, 0,0,6, 2,1,6);
    add(0,1,32'h103,1, 0,0,32'h103, 0,0,0);
    add(0,0,0,1, 0,0,32'h103, 2,1,32'h103);
    // reset during HALT with a full queue
    add(0,1,248,0, 0,0,248, 1,0,0);
    add(0,0,0,0, 1,248,252, 1,0,0);
    add(0,0,0,0, 1,248,256, 1,0,0);
    add(0,0,0,0, 1,248,256, 2,1,256);
    add(1,0,0,0, 0,0,0, 2,0,0);
    add(0,0,0,1, 0,0,0, 2,0,0);
    add(0,0,0,1, 1,0,4, 2,0,0);
    add(0,0,0,1, 1,4,8, 2,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      reset          = tbl[i].rst;
      redirect_valid = tbl[i].rv;
      redirect_pc    = tbl[i].rpc;
      out_ready      = tbl[i].rdy;
      tick();
      chk("out_valid", i, 32'(out_valid), 32'(tbl[i].ev));
      chk("imem_pc", i, imem_pc, tbl[i].eipc);
      if (tbl[i].ev) begin
        chk("out_pc", i, out_pc, tbl[i].eopc);
        chk("out_instr", i, out_instr, mem_word(tbl[i].eopc));
      end else begin
        chk("out_pc_idle", i, out_pc, 32'h0);
        chk("out_instr_idle", i, out_instr, 32'h0);
      end
      if (tbl[i].fm >= 1) chk("fault", i, 32'(fault), 32'(tbl[i].ef));
      if (tbl[i].fm == 2) chk("fault_pc", i, fault_pc, tbl[i].efp);
    end

    // streaming run from reset to the end of memory
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    for (int a = 0; a < int'(MB); a += 4) exp_q.push_back(32'(a));
    seen = 1'b0;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      rdy = ($urandom_range(0, 3) != 0);
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) begin
          chk("sb_extra", c, out_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_pc", c, out_pc, e);
          chk("sb_instr", c, out_instr, mem_word(e));
        end
      end
      if (fault && !seen) begin
        seen = 1'b1;
        chk("sb_fault_pc", c, fault_pc, 32'd256);
        chk("sb_halt_pc", c, imem_pc, 32'd256);
      end
      if (seen && exp_q.size() == 0 && !out_valid) done = 1'b1;
      if (!done) tick();
    end
    chk("sb_left", 0, 32'(exp_q.size()), 32'h0);
    chk("sb_fault_seen", 0, 32'(seen), 32'h1);
    chk("sb_finished", 0, 32'(done), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
